fwd_hazard_unit: RTL

- Parametrised successor to the pipeline forwarding logic for the riscv merge-sort core with hazard control and cache.
- Generates per-source EX and ID bypass selects for NSRC operands, with x0 exclusion and MEM-over-WB priority.
- Adds a sequential hazard controller:
  - multi-cycle load-use stall (LU_LAT bubbles);
  - cache-miss freeze of the whole pipeline, with timeout detection.
- Sits beside the ID/EX/MEM/WB pipeline registers; drives their hold and bubble controls.

---
 rtl/fwd_hazard_unit.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: operand bypass select generation plus a small hazard FSM
// that inserts load-use bubbles and freezes the pipeline on a cache miss.
// Optional build macro HAZ_PERF_EN adds stall/freeze cycle counters; without
// it the counter ports are tied to zero and no counter flops exist.

// Per-operand compare lane: EX/ID bypass selects and load-use match.
module fwd_hazard_lane #(
  parameter int AW       = 5,
  parameter int ZERO_REG = 1
) (
  input  logic          en,
  input  logic [AW-1:0] exRs,
  input  logic [AW-1:0] idRs,
  input  logic [AW-1:0] exRd,
  input  logic          exWenN,
  input  logic [AW-1:0] memRd,
  input  logic          memWenN,
  input  logic [AW-1:0] wbRd,
  input  logic          wbWenN,
  output logic [1:0]    exSel,
  output logic          idSel,
  output logic          luMatch
);
  // A write to x0 is discarded by the regfile, so it must never bypass.
  function automatic logic match(input logic [AW-1:0] src, input logic [AW-1:0] rd,
                                 input logic wenN);
    return (src == rd) && !wenN && !((ZERO_REG != 0) && (src == '0));
  endfunction

  // MEM is younger than WB, so it wins when both hold the same register.
  always_comb begin
    exSel   = 2'b00;
    idSel   = 1'b0;
    luMatch = 1'b0;
    if (en) begin
      if (match(exRs, memRd, memWenN))     exSel = 2'b01;
      else if (match(exRs, wbRd, wbWenN))  exSel = 2'b10;
      idSel   = match(idRs, wbRd, wbWenN);
      luMatch = match(idRs, exRd, exWenN);
    end
  end
endmodule

module fwd_hazard_unit #(
  parameter int NSRC         = 2,
  parameter int AW           = 5,
  parameter int LU_LAT       = 1,
  parameter int MISS_TIMEOUT = 255,
  parameter int ZERO_REG     = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NSRC*AW-1:0]   ex_rs,
  input  logic [NSRC*AW-1:0]   id_rs,
  input  logic [AW-1:0]        ex_rd,
  input  logic                 ex_wen_n,
  input  logic                 ex_is_load,
  input  logic [AW-1:0]        mem_rd,
  input  logic                 mem_wen_n,
  input  logic [AW-1:0]        wb_rd,
  input  logic                 wb_wen_n,
  input  logic                 mem_req_valid,
  input  logic                 cache_ready,
  output logic [2*NSRC-1:0]    fwd_ex_sel,
  output logic [NSRC-1:0]      fwd_id_sel,
  output logic                 stall_front,
  output logic                 bubble_ex,
  output logic                 freeze_all,
  output logic [1:0]           hz_state,
  output logic                 timeout_err,
  output logic [31:0]          lu_stall_cnt,
  output logic [31:0]          miss_stall_cnt
);
  localparam int MCW = $clog2(MISS_TIMEOUT + 1);
  localparam logic [MCW-1:0] MISS_MAX  = MCW'(MISS_TIMEOUT);
  localparam logic [MCW-1:0] MISS_TRIP = MCW'(MISS_TIMEOUT - 1);
  localparam logic [2:0]     LU_INIT   = 3'(LU_LAT - 1);

  typedef enum logic [1:0] {RUN = 2'b00, LU_WAIT = 2'b01, MISS = 2'b10} hzState_t;

  hzState_t        state, nextState;
  logic [2:0]      luCnt, nextLuCnt;
  logic [MCW-1:0]  missCnt;
  logic            timeoutErr;
  logic [NSRC-1:0] luMatch;
  logic            luHit, miss, stallFront;

  genvar i;
  generate
    for (i = 0; i < NSRC; i++) begin : gLane
      fwd_hazard_lane #(.AW(AW), .ZERO_REG(ZERO_REG)) uLane (
        .en      (rst_n),
        .exRs    (ex_rs[i*AW +: AW]),
        .idRs    (id_rs[i*AW +: AW]),
        .exRd    (ex_rd),
        .exWenN  (ex_wen_n),
        .memRd   (mem_rd),
        .memWenN (mem_wen_n),
        .wbRd    (wb_rd),
        .wbWenN  (wb_wen_n),
        .exSel   (fwd_ex_sel[2*i +: 2]),
        .idSel   (fwd_id_sel[i]),
        .luMatch (luMatch[i])
      );
    end
  endgenerate

  assign luHit = ex_is_load && (|luMatch);
  assign miss  = mem_req_valid && !cache_ready;

  // Next-state and stall decode; a miss always overrides load-use bubbles.
  always_comb begin
    nextState  = state;
    nextLuCnt  = luCnt;
    stallFront = 1'b0;
    unique case (state)
      RUN: begin
        if (miss) nextState = MISS;
        else if (luHit) begin
          stallFront = 1'b1;
          nextLuCnt  = LU_INIT;
          nextState  = (LU_LAT > 1) ? LU_WAIT : RUN;
        end
      end
      LU_WAIT: begin
        if (miss) nextState = MISS;
        else begin
          stallFront = 1'b1;
          nextLuCnt  = luCnt - 3'd1;
          if (luCnt <= 3'd1) nextState = RUN;
        end
      end
      MISS: begin
        // luCnt is left untouched so an interrupted load-use wait resumes.
        if (!miss) nextState = (luCnt != 3'd0) ? LU_WAIT : RUN;
      end
      default: nextState = RUN;
    endcase
  end

  assign stall_front = rst_n && stallFront;
  assign bubble_ex   = rst_n && stallFront;
  assign freeze_all  = rst_n && miss;
  assign hz_state    = state;
  assign timeout_err = timeoutErr;

  // State, bubble counter and saturating miss-length counter with sticky timeout.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= RUN;
      luCnt      <= 3'd0;
      missCnt    <= '0;
      timeoutErr <= 1'b0;
    end else begin
      state <= nextState;
      luCnt <= nextLuCnt;
      if (miss) begin
        if (missCnt != MISS_MAX)  missCnt    <= missCnt + 1'b1;
        if (missCnt >= MISS_TRIP) timeoutErr <= 1'b1;
      end else begin
        missCnt <= '0;
      end
    end
  end

`ifdef HAZ_PERF_EN
  logic [31:0] luStallCnt, missStallCnt;

  // Free-running cycle counters for load-use stall and cache freeze.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      luStallCnt   <= 32'd0;
      missStallCnt <= 32'd0;
    end else begin
      if (stall_front) luStallCnt   <= luStallCnt + 32'd1;
      if (freeze_all)  missStallCnt <= missStallCnt + 32'd1;
    end
  end

  assign lu_stall_cnt   = luStallCnt;
  assign miss_stall_cnt = missStallCnt;
`else
  assign lu_stall_cnt   = 32'd0;
  assign miss_stall_cnt = 32'd0;
`endif
endmodule
